// File: rtl/fnd_scan_if.sv
// Handshake, brightness/blanking controls and digit-drive outputs of the FND scan scheduler.
interface fnd_scan_if;
    logic        i_valid;
    logic [13:0] i_value;
    logic        o_ready;
    logic [2:0]  i_bright;
    logic        i_lz_en;
    logic [3:0]  o_fnd_com;
    logic [3:0]  o_bcd;
    logic        o_frame_done;

    modport master (
        output i_valid, i_value, i_bright, i_lz_en,
        input  o_ready, o_fnd_com, o_bcd, o_frame_done
    );

    modport slave (
        input  i_valid, i_value, i_bright, i_lz_en,
        output o_ready, o_fnd_com, o_bcd, o_frame_done
    );
endinterface

// File: rtl/fnd_scan_scheduler.sv
// 4-digit common-anode FND scan scheduler: digit scan timing, sequential binary-to-BCD
// conversion, frame-aligned commit, leading-zero blanking and 8-level PWM brightness.
//
// state | meaning
// IDLE  | ready for a new value
// CONV  | double-dabble running, one shift/add-3 step per clock (14 steps)
// HOLD  | BCD result waiting for the next frame boundary to be committed
module fnd_scan_scheduler #(
    parameter int CLK_HZ  = 100_000_000,
    parameter int SCAN_HZ = 1_000
) (
    input  logic     clk,
    input  logic     reset,
    fnd_scan_if.slave bus
);
    localparam int DIV = CLK_HZ / SCAN_HZ;
    localparam int CW  = $clog2(DIV);

    typedef enum logic [1:0] {IDLE, CONV, HOLD} state_t;

    state_t        state, state_nx;
    logic [29:0]   dd, dd_nx;           // {bcd[15:0], bin[13:0]}
    logic [3:0]    step, step_nx;
    logic [CW-1:0] cnt;
    logic [1:0]    sel;
    logic [15:0]   display;
    logic [2:0]    bright_sh;
    logic          lz_sh;
    logic          tick, boundary, xfer;
    logic [13:0]   sat_value;
    logic [31:0]   on_th;
    logic [1:0]    msd;
    logic          lit;

    assign tick      = (cnt == CW'(DIV - 1));
    assign boundary  = tick && (sel == 2'd3);
    assign bus.o_ready = reset || (state == IDLE);
    assign xfer      = bus.i_valid && bus.o_ready;
    assign sat_value = (bus.i_value > 14'd9999) ? 14'd9999 : bus.i_value;

    function automatic logic [29:0] dd_step(input logic [29:0] d);
        logic [29:0] t;
        t = d;
        for (int k = 0; k < 4; k++) begin
            if (t[14 + 4*k +: 4] >= 4'd5) t[14 + 4*k +: 4] = t[14 + 4*k +: 4] + 4'd3;
        end
        return t << 1;
    endfunction

    // FSM next-state and conversion datapath
    always_comb begin
        state_nx = state;
        dd_nx    = dd;
        step_nx  = step;
        case (state)
            IDLE: begin
                if (xfer) begin
                    state_nx = CONV;
                    dd_nx    = {16'd0, sat_value};
                    step_nx  = 4'd13;
                end
            end
            CONV: begin
                dd_nx   = dd_step(dd);
                step_nx = step - 4'd1;
                if (step == 4'd0) state_nx = HOLD;
            end
            HOLD: begin
                // boundary in the capture cycle is seen while still IDLE, so it cannot commit
                if (boundary) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // FSM and conversion registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            dd    <= '0;
            step  <= '0;
        end else begin
            state <= state_nx;
            dd    <= dd_nx;
            step  <= step_nx;
        end
    end

    // digit dwell counter and digit select
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
            sel <= '0;
        end else if (tick) begin
            cnt <= '0;
            sel <= sel + 2'd1;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // frame-boundary sampling of settings and commit of a finished conversion
    always_ff @(posedge clk) begin
        if (reset) begin
            display   <= '0;
            bright_sh <= 3'd7;
            lz_sh     <= 1'b0;
        end else if (boundary) begin
            bright_sh <= bus.i_bright;
            lz_sh     <= bus.i_lz_en;
            if (state == HOLD) display <= dd[29:14];
        end
    end

    // most-significant nonzero digit; digit 0 counts even when zero so "0" is shown
    always_comb begin
        msd = 2'd0;
        for (int k = 1; k < 4; k++) begin
            if (display[4*k +: 4] != 4'd0) msd = 2'(k);
        end
    end

    assign on_th = ((32'(bright_sh) + 32'd1) * 32'(DIV)) >> 3;
    assign lit   = (32'(cnt) < on_th) && !(lz_sh && (sel > msd));

    // registered digit drive, one cycle behind cnt/sel
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.o_fnd_com    <= 4'b1111;
            bus.o_bcd        <= 4'd0;
            bus.o_frame_done <= 1'b0;
        end else begin
            bus.o_fnd_com    <= lit ? ~(4'b0001 << sel) : 4'b1111;
            bus.o_bcd        <= display[{sel, 2'b00} +: 4];
            bus.o_frame_done <= boundary;
        end
    end
endmodule

// File: tb/tb_fnd_scan_scheduler.sv
// Testbench for fnd_scan_scheduler (DIV = 8): random values and settings, frame-level scoreboard.
module tb_fnd_scan_scheduler;
    logic clk = 1'b0;
    logic reset;

    fnd_scan_if bus();

    fnd_scan_scheduler #(.CLK_HZ(800), .SCAN_HZ(100)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        int value;
        int bright;
        bit lz;
    } frame_t;

    frame_t exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    int frame_no   = 0;
    int disp_cur   = 0;
    int pend_val   = 0;
    int pend_frame = 0;
    bit pend_valid = 0;
    int cur_bright = 7;
    bit cur_lz     = 0;
    int didx       = 0;

    localparam int ND = 5;
    int dir_val [ND] = '{1234, 12000, 0, 7, 1005};
    int dir_brt [ND] = '{7, 7, 1, 0, 7};
    bit dir_lz  [ND] = '{0, 0, 1, 1, 1};
    int dir_d   [ND] = '{3, 17, 32, 18, 5};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    function automatic int sat(input int v);
        return (v > 9999) ? 9999 : v;
    endfunction

    function automatic int ndig(input int v);
        if (v >= 1000) return 4;
        if (v >= 100)  return 3;
        if (v >= 10)   return 2;
        return 1;
    endfunction

    function automatic int pow10(input int j);
        case (j)
            0: return 1;
            1: return 10;
            2: return 100;
            default: return 1000;
        endcase
    endfunction

    // expected {fnd_com x8, bcd x8} for one digit slot; sample c occupies nibble c
    function automatic logic [63:0] exp_digit(input frame_t f, input int j);
        logic [31:0] com;
        logic [31:0] bcd;
        logic [3:0]  one_hot;
        int dv;
        bit on;
        one_hot = 4'b0001 << j;
        dv = (f.value / pow10(j)) % 10;
        for (int c = 0; c < 8; c++) begin
            on = (c < f.bright + 1) && (!f.lz || j < ndig(f.value));
            com[4*c +: 4] = on ? ~one_hot : 4'hF;
            bcd[4*c +: 4] = 4'(dv);
        end
        return {com, bcd};
    endfunction

    // monitor: collects the 32 samples following each o_frame_done and scores them
    initial begin : monitor
        logic [3:0]  com_s [32];
        logic [3:0]  bcd_s [32];
        logic [31:0] fd;
        logic [31:0] ac, ab;
        bit abort;
        bit got;
        int fidx;
        frame_t f;
        fidx = 0;
        forever begin
            got = 0;
            for (int i = 0; i < 100; i++) begin
                @(negedge clk);
                if (bus.o_frame_done === 1'b1 && reset === 1'b0) begin
                    got = 1;
                    break;
                end
            end
            if (!got) begin
                n_cmp++;
                n_bad++;
                $display("FAIL frame_sync: no o_frame_done within 100 clk, got 0 expected 1");
                continue;
            end
            abort = 0;
            while (!abort) begin
                for (int s = 0; s < 32; s++) begin
                    @(negedge clk);
                    if (reset) abort = 1;
                    com_s[s] = bus.o_fnd_com;
                    bcd_s[s] = bus.o_bcd;
                    fd[s]    = bus.o_frame_done;
                end
                if (abort) break;
                fidx++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL scoreboard_empty: frame %0d got output, expected no frame", fidx);
                end else begin
                    f = exp_q.pop_front();
                    for (int j = 0; j < 4; j++) begin
                        for (int c = 0; c < 8; c++) begin
                            ac[4*c +: 4] = com_s[8*j + c];
                            ab[4*c +: 4] = bcd_s[8*j + c];
                        end
                        check($sformatf("frame%0d_digit%0d(val=%0d,br=%0d,lz=%0d)", fidx, j, f.value, f.bright, f.lz),
                              {ac, ab}, exp_digit(f, j));
                    end
                    check($sformatf("frame%0d_done_timing", fidx), 64'(fd), 64'(32'h8000_0000));
                end
                if (fd[31] !== 1'b1) abort = 1;
            end
        end
    end

    task automatic finish_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    endtask

    task automatic wait_frame();
        bit got;
        got = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (bus.o_frame_done === 1'b1) begin
                got = 1;
                break;
            end
        end
        if (!got) begin
            n_cmp++;
            n_bad++;
            $display("FAIL frame_wait: no o_frame_done within 64 clk, got 0 expected 1");
            finish_run();
        end
        frame_no++;
    endtask

    task automatic frame_step(input bit allow);
        bit do_x;
        int v, d, m, k;
        wait_frame();
        check($sformatf("ready_at_frame%0d", frame_no), 64'(bus.o_ready),
              (pend_valid && pend_frame > frame_no) ? 64'd0 : 64'd1);
        if (pend_valid && pend_frame <= frame_no) pend_valid = 0;

        do_x = 0;
        v = 0;
        d = 1;
        if (allow && !pend_valid && didx < ND) begin
            cur_bright = dir_brt[didx];
            cur_lz     = dir_lz[didx];
            v          = dir_val[didx];
            d          = dir_d[didx];
            didx++;
            do_x = 1;
        end else begin
            if ($urandom_range(0, 1) == 1) cur_bright = $urandom_range(0, 7);
            if ($urandom_range(0, 3) == 0) cur_lz = ~cur_lz;
            if (allow && !pend_valid && $urandom_range(0, 3) != 0) begin
                case ($urandom_range(0, 3))
                    0: v = $urandom_range(0, 9);
                    1: v = $urandom_range(0, 999);
                    2: v = $urandom_range(0, 16383);
                    default: v = 10000 + $urandom_range(0, 6383);
                endcase
                d = $urandom_range(1, 32);
                do_x = 1;
            end
        end
        bus.i_bright = 3'(cur_bright);
        bus.i_lz_en  = cur_lz;

        if (do_x) begin
            m = (d + 15 + 31) / 32;
            pend_val   = sat(v);
            pend_frame = frame_no + m;
            pend_valid = 1;
        end
        if (pend_valid && pend_frame == frame_no + 1) disp_cur = pend_val;
        exp_q.push_back('{disp_cur, cur_bright, cur_lz});

        if (do_x) begin
            repeat (d - 1) @(negedge clk);
            bus.i_value = 14'(v);
            bus.i_valid = 1'b1;
            check("ready_before_xfer", 64'(bus.o_ready), 64'd1);
            @(posedge clk);
            #1;
            check($sformatf("ready_after_xfer_of_%0d", v), 64'(bus.o_ready), 64'd0);
            k = $urandom_range(1, 10);
            if (d + k <= 28 && $urandom_range(0, 1) == 1) begin
                bus.i_value = 14'($urandom_range(0, 16383));
                repeat (k) @(posedge clk);
                #1;
            end
            bus.i_valid = 1'b0;
        end
    endtask

    initial begin : stimulus
        reset        = 1'b1;
        bus.i_valid  = 1'b0;
        bus.i_value  = 14'd0;
        bus.i_bright = 3'd7;
        bus.i_lz_en  = 1'b0;
        #1;
        check("ready_during_reset", 64'(bus.o_ready), 64'd1);
        repeat (2) @(posedge clk);
        #1;
        check("reset_fnd_com", 64'(bus.o_fnd_com), 64'hF);
        check("reset_bcd", 64'(bus.o_bcd), 64'd0);
        check("reset_frame_done", 64'(bus.o_frame_done), 64'd0);
        exp_q.push_back('{0, 7, 1'b0});
        reset = 1'b0;

        for (int i = 0; i < 40; i++) frame_step(1'b1);
        for (int i = 0; i < 3; i++) frame_step(1'b0);

        // reset 5 clocks into a conversion
        wait_frame();
        bus.i_value = 14'd4321;
        bus.i_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
        check("ready_after_xfer_pre_reset", 64'(bus.o_ready), 64'd0);
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("ready_reset_in_conv", 64'(bus.o_ready), 64'd1);
        exp_q.delete();
        @(posedge clk);
        #1;
        check("midreset_fnd_com", 64'(bus.o_fnd_com), 64'hF);
        check("midreset_bcd", 64'(bus.o_bcd), 64'd0);
        check("midreset_ready", 64'(bus.o_ready), 64'd1);
        cur_bright   = 7;
        cur_lz       = 1;
        bus.i_bright = 3'd7;
        bus.i_lz_en  = 1'b1;
        disp_cur     = 0;
        pend_valid   = 0;
        frame_no     = 0;
        exp_q.push_back('{0, 7, 1'b1});
        @(posedge clk);
        #1;
        reset = 1'b0;

        for (int i = 0; i < 2; i++) frame_step(1'b0);
        wait_frame();
        @(posedge clk);
        #1;
        finish_run();
    end
endmodule
